fir_filter_mc: RTL and testbench

Parametrised, multi-channel, time-multiplexed FIR filter: the successor to the fixed 4-tap `fir_filter`. It generalises tap count, data, coefficient and output widths, and channel count. One signed MAC is shared serially across taps, and each channel keeps its own delay line. The block adds ready/valid backpressure on both ports and optional output saturation, and sits between the sample source and the downstream consumer in the datapath.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_mac.sv | 34 +++
 rtl/fir_filter_mc.sv | 162 ++++++++++++++++
 tb/tb_fir_filter_mc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the multi-channel time-multiplexed FIR.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + clog2(taps);
  endfunction

  function automatic int ch_width(input int channels);
    return (channels <= 1) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear and enable; acc_nxt is the
// running sum including the current product, so the caller can capture it on the last tap.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = acc_width(DATA_W, COEF_W, 4)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] h,
  output logic signed [ACC_W-1:0]  acc_nxt
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;

  assign prod    = PROD_W'(x) * PROD_W'(h);
  assign acc_nxt = acc + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/fir_filter_mc.sv
// Multi-channel FIR with one serial MAC, per-channel delay lines and ready/valid on both sides.
// Define FIR_SAT_EN to clamp results to the signed OUT_W range; otherwise results wrap.
module fir_filter_mc
  import fir_pkg::*;
#(
  parameter  int TAPS     = 4,
  parameter  int DATA_W   = 16,
  parameter  int COEF_W   = 16,
  parameter  int OUT_W    = 32,
  parameter  int CHANNELS = 1,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [TAPS*COEF_W-1:0]   coeff_in,
  input  logic                     valid_in,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          chan_in,
  input  logic signed [DATA_W-1:0] signal_in,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic [CH_W-1:0]          chan_out,
  output logic signed [OUT_W-1:0]  signal_out
);

  localparam int            ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int            TAP_W  = clog2(TAPS);
  localparam int            EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

  function automatic logic signed [OUT_W-1:0] fit_out(input logic signed [ACC_W-1:0] a);
    logic signed [EXT_W-1:0] e;
    e = EXT_W'(a);
`ifdef FIR_SAT_EN
    if (!(&e[EXT_W-1:OUT_W-1]) && (|e[EXT_W-1:OUT_W-1])) begin
      return e[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
    return e[OUT_W-1:0];
  endfunction

  fir_state_t state, state_nxt;

  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] dly  [CHANNELS][TAPS];
  logic [TAP_W-1:0]         tap_cnt;
  logic [CH_W-1:0]          chan_r;
  logic                     ready_r;
  logic                     accept, chan_ok, take, last_tap;
  logic                     mac_en, mac_clr, vld_p1;
  logic signed [DATA_W-1:0] x_p0;
  logic signed [COEF_W-1:0] h_p0;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [OUT_W-1:0]  sig_p1;

  // ready_r is only ever set while the FSM rests in IDLE
  assign in_ready = ready_r & ~load;
  assign accept   = valid_in & in_ready;
  assign chan_ok  = {1'b0, chan_in} < CH_LIM;
  assign take     = accept & chan_ok;
  assign last_tap = (tap_cnt == TAP_W'(TAPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = OUT;
      OUT:     if (ready_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mac_en  = 1'b0;
    mac_clr = rst;
    vld_p1  = 1'b0;
    case (state)
      IDLE:    mac_clr = rst | take;
      MAC:     mac_en  = 1'b1;
      OUT:     vld_p1  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r <= 1'b0;
      tap_cnt <= '0;
      chan_r  <= '0;
    end else begin
      ready_r <= (state_nxt == IDLE);
      if (take) begin
        tap_cnt <= '0;
        chan_r  <= chan_in;
      end else if (mac_en) begin
        tap_cnt <= tap_cnt + TAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (load && state == IDLE) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= coeff_in[k*COEF_W +: COEF_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS; k++) dly[c][k] <= '0;
    end else if (take) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (chan_in == CH_W'(c)) begin
          dly[c][0] <= signal_in;
          for (int k = 1; k < TAPS; k++) dly[c][k] <= dly[c][k-1];
        end
      end
    end
  end

  // p0: tap select into the shared MAC
  assign x_p0 = dly[chan_r][tap_cnt];
  assign h_p0 = coef[tap_cnt];

  fir_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .clr    (mac_clr),
    .en     (mac_en),
    .x      (x_p0),
    .h      (h_p0),
    .acc_nxt(acc_nxt)
  );

  // p1: final sum fitted to OUT_W and held for the consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_p1 <= '0;
    end else if (mac_en && last_tap) begin
      sig_p1 <= fit_out(acc_nxt);
    end
  end

  assign valid_out  = vld_p1;
  assign chan_out   = chan_r;
  assign signal_out = sig_p1;

endmodule

// File: tb/tb_fir_filter_mc.sv
// Directed bench for fir_filter_mc with a sum-of-products reference model and transfer scoreboard.
module tb_fir_filter_mc;

  localparam int TAPS     = 4;
  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int OUT_W    = 32;
  localparam int CHANNELS = 3;
  localparam int CH_W     = 2;

  logic                     clk = 1'b0;
  logic                     rst, load, valid_in, ready_out;
  logic                     in_ready, valid_out;
  logic [TAPS*COEF_W-1:0]   coeff_in;
  logic [CH_W-1:0]          chan_in, chan_out;
  logic signed [DATA_W-1:0] signal_in;
  logic signed [OUT_W-1:0]  signal_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_filter_mc #(
    .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .CHANNELS(CHANNELS)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .coeff_in(coeff_in),
    .valid_in(valid_in), .in_ready(in_ready), .chan_in(chan_in), .signal_in(signal_in),
    .valid_out(valid_out), .ready_out(ready_out), .chan_out(chan_out), .signal_out(signal_out)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: coefficients, per-channel histories, expected transfers.
  typedef struct {
    logic [CH_W-1:0]         ch;
    logic signed [OUT_W-1:0] y;
  } exp_t;

  longint                  hm [TAPS];
  longint                  xm [CHANNELS][TAPS];
  bit                      busy = 0;
  exp_t                    q [$];
  exp_t                    e_cur;
  bit                      hold = 0;
  logic [CH_W-1:0]         hold_ch;
  logic signed [OUT_W-1:0] hold_y;

  function automatic logic signed [OUT_W-1:0] model_fit(input longint s);
    longint lim;
    lim = longint'(1) <<< (OUT_W - 1);
`ifdef FIR_SAT_EN
    if (s > lim - 1) return OUT_W'(lim - 1);
    if (s < -lim) return OUT_W'(-lim);
`endif
    return OUT_W'(s);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) hm[k] = 0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS; k++) xm[c][k] = 0;
      busy = 0;
      hold = 0;
      q.delete();
    end else begin
      if (load && !busy)
        for (int k = 0; k < TAPS; k++) hm[k] = $signed(coeff_in[k*COEF_W +: COEF_W]);
      if (hold) begin
        check("hold_valid", valid_out, 1);
        check("hold_chan", chan_out, hold_ch);
        check("hold_data", signal_out, hold_y);
      end
      if (valid_out) begin
        if (ready_out) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got chan %0d data %0d expected no output", chan_out, signal_out);
          end else begin
            e_cur = q.pop_front();
            check("model_chan", chan_out, e_cur.ch);
            check("model_data", signal_out, e_cur.y);
          end
          busy = 0;
          hold = 0;
        end else begin
          hold    = 1;
          hold_ch = chan_out;
          hold_y  = signal_out;
        end
      end else begin
        hold = 0;
      end
      if (valid_in && in_ready && chan_in < CHANNELS) begin
        longint s;
        int c;
        c = int'(chan_in);
        for (int k = TAPS - 1; k > 0; k--) xm[c][k] = xm[c][k-1];
        xm[c][0] = signal_in;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += hm[k] * xm[c][k];
        e_cur.ch = chan_in;
        e_cur.y  = model_fit(s);
        q.push_back(e_cur);
        busy = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coefs(input int a, input int b, input int c, input int d);
    coeff_in = {COEF_W'(d), COEF_W'(c), COEF_W'(b), COEF_W'(a)};
    load = 1;
    tick();
    load = 0;
  endtask

  task automatic send(input int ch, input int x);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1);
    chan_in   = CH_W'(ch);
    signal_in = DATA_W'(x);
    valid_in  = 1;
    tick();
    valid_in  = 0;
  endtask

  task automatic expect_out(input string name, input int ch,
                            input logic signed [OUT_W-1:0] y, input bit chk_lat);
    int lat = 0;
    while (!valid_out && lat < 40) begin
      tick();
      lat++;
    end
    check({name, "_valid"}, valid_out, 1);
    if (chk_lat) check({name, "_latency"}, lat + 1, TAPS + 1);
    check({name, "_chan"}, chan_out, ch);
    check({name, "_data"}, signal_out, y);
    if (ready_out) begin
      tick();
      check({name, "_drop"}, valid_out, 0);
      check({name, "_in_ready"}, in_ready, 1);
    end
  endtask

  task automatic quiet(input string name, input int cycles);
    bit seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (valid_out) seen = 1;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; load = 0; valid_in = 0; ready_out = 1;
    coeff_in = '0; chan_in = '0; signal_in = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_signal_out", signal_out, 0);
    check("rst_chan_out", chan_out, 0);
    rst = 0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    load_coefs(1, 2, 3, 4);
    send(0, 1); expect_out("imp0", 0, 1, 1);
    send(0, 0); expect_out("imp1", 0, 2, 1);
    send(0, 0); expect_out("imp2", 0, 3, 1);
    send(0, 0); expect_out("imp3", 0, 4, 1);
    send(0, 0); expect_out("imp4", 0, 0, 1);

    load_coefs(1, 1, 1, 1);
    send(0, 1);  expect_out("iso_a", 0, 1, 1);
    send(1, 10); expect_out("iso_b", 1, 10, 1);
    send(0, 1);  expect_out("iso_c", 0, 2, 1);
    send(1, 10); expect_out("iso_d", 1, 20, 1);
    send(0, 1);  expect_out("iso_e", 0, 3, 1);

    send(3, 77);
    check("oor_in_ready", in_ready, 1);
    quiet("oor_no_output", 8);

    ready_out = 0;
    send(0, 1);
    expect_out("bp", 0, 4, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", valid_out, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_data", signal_out, 4);
    end
    ready_out = 1;
    tick();
    check("bp_release", valid_out, 0);

    coeff_in  = {4{16'sd2}};
    load      = 1;
    chan_in   = 2;
    signal_in = 99;
    valid_in  = 1;
    #1;
    check("race_in_ready", in_ready, 0);
    tick();
    load = 0;
    valid_in = 0;
    quiet("race_no_accept", 8);
    send(2, 5);
    coeff_in = {4{16'sd9}};
    load = 1;
    tick();
    load = 0;
    expect_out("race_mac", 2, 10, 0);
    send(2, 0); expect_out("race_coef", 2, 10, 1);

    send(0, 1);
    tick();
    rst = 1;
    tick();
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_data", signal_out, 0);
    rst = 0;
    tick();
    check("mid_rst_ready_after", in_ready, 1);
    quiet("mid_rst_no_output", 6);
    load_coefs(1, 2, 3, 4);
    send(0, 1); expect_out("restart0", 0, 1, 1);
    send(0, 0); expect_out("restart1", 0, 2, 1);

    load_coefs(32767, 32767, 32767, 32767);
    send(1, 32767); expect_out("sat1", 1, 1073676289, 1);
    send(1, 32767); expect_out("sat2", 1, 2147352578, 1);
`ifdef FIR_SAT_EN
    send(1, 32767); expect_out("sat3", 1, 32'sh7FFFFFFF, 1);
    send(1, 32767); expect_out("sat4", 1, 32'sh7FFFFFFF, 1);
`else
    send(1, 32767); expect_out("sat3", 1, -1073938429, 1);
    send(1, 32767); expect_out("sat4", 1, 32'shFFFC0004, 1);
`endif

    tick();
    tick();
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
